// File: rtl/window_peak_sat_pkg.sv
// Shared defaults and state encoding for the window peak / saturation counter.
package window_peak_sat_pkg;

    localparam int W_DEFAULT       = 8;
    localparam int WIN_DEFAULT     = 8;
    localparam int SAT_VAL_DEFAULT = 200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/window_peak_sat_clamp_cmp.sv
// Combinational clamp-and-compare: limits a sample to SAT_VAL and folds it into the running peak.
module window_peak_sat_clamp_cmp
    import window_peak_sat_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int SAT_VAL = SAT_VAL_DEFAULT
) (
    input  logic [W-1:0] sample_i,
    input  logic [W-1:0] peak_i,
    output logic [W-1:0] clamped_o,
    output logic [W-1:0] new_max_o,
    output logic         is_sat_o,
    output logic         is_over_o
);

    localparam logic [W-1:0] SAT_W = W'(SAT_VAL);

    function automatic logic [W-1:0] sat_clamp(input logic [W-1:0] v);
        return (v > SAT_W) ? SAT_W : v;
    endfunction

    always_comb begin
        clamped_o = sat_clamp(sample_i);
        is_over_o = (sample_i > SAT_W);
        // Equality is judged after the clamp so overrange samples count as saturated.
        is_sat_o  = (clamped_o == SAT_W);
        new_max_o = (clamped_o > peak_i) ? clamped_o : peak_i;
    end

endmodule

// File: rtl/window_peak_sat.sv
// Collects WIN clamped samples, reports their peak and saturated-sample count
// under an output valid/ready handshake, with a sticky overrange flag.
module window_peak_sat
    import window_peak_sat_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int WIN     = WIN_DEFAULT,
    parameter int SAT_VAL = SAT_VAL_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               y_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               peak_out,
    output logic [$clog2(WIN+1)-1:0]   sat_count,
    output logic                       overrange
);

    localparam int CW = $clog2(WIN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    peak_q, peak_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   satc_q, satc_d;
    logic [W-1:0]    peak_out_q, peak_out_d;
    logic [CW-1:0]   sat_count_q, sat_count_d;
    logic            out_valid_q, out_valid_d;
    logic            overrange_q, overrange_d;

    logic [W-1:0]    clamped;
    logic [W-1:0]    new_max;
    logic            is_sat;
    logic            is_over;
    logic            accept;

    window_peak_sat_clamp_cmp #(
        .W       (W),
        .SAT_VAL (SAT_VAL)
    ) u_clamp_cmp (
        .sample_i  (y_in),
        .peak_i    (peak_q),
        .clamped_o (clamped),
        .new_max_o (new_max),
        .is_sat_o  (is_sat),
        .is_over_o (is_over)
    );

    // Reset and clear both block intake in the cycle they are asserted.
    assign in_ready = !rst && !clear && (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        peak_d      = peak_q;
        cnt_d       = cnt_q;
        satc_d      = satc_q;
        peak_out_d  = peak_out_q;
        sat_count_d = sat_count_q;
        out_valid_d = out_valid_q;
        overrange_d = overrange_q || (accept && is_over);

        if (clear) begin
            state_d     = IDLE;
            peak_d      = '0;
            cnt_d       = '0;
            satc_d      = '0;
            peak_out_d  = '0;
            sat_count_d = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        peak_d = clamped;
                        cnt_d  = CW'(1);
                        satc_d = CW'(is_sat);
                        if (WIN == 1) begin
                            state_d     = HOLD;
                            peak_out_d  = clamped;
                            sat_count_d = CW'(is_sat);
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        peak_d = new_max;
                        cnt_d  = cnt_q + CW'(1);
                        satc_d = satc_q + CW'(is_sat);
                        if (cnt_q == LAST_CNT) begin
                            state_d     = HOLD;
                            peak_out_d  = new_max;
                            sat_count_d = satc_q + CW'(is_sat);
                            out_valid_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        cnt_d       = '0;
                        satc_d      = '0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    satc_d      = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            peak_q      <= '0;
            cnt_q       <= '0;
            satc_q      <= '0;
            peak_out_q  <= '0;
            sat_count_q <= '0;
            out_valid_q <= 1'b0;
            overrange_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            peak_q      <= peak_d;
            cnt_q       <= cnt_d;
            satc_q      <= satc_d;
            peak_out_q  <= peak_out_d;
            sat_count_q <= sat_count_d;
            out_valid_q <= out_valid_d;
            overrange_q <= overrange_d;
        end
    end

    assign out_valid = out_valid_q;
    assign peak_out  = peak_out_q;
    assign sat_count = sat_count_q;
    assign overrange = overrange_q;

endmodule

// File: tb/tb_window_peak_sat.sv
// Directed bench for window_peak_sat with WIN=4, SAT_VAL=200.
module tb_window_peak_sat;

    localparam int W       = 8;
    localparam int WIN     = 4;
    localparam int SAT_VAL = 200;
    localparam int CW      = $clog2(WIN + 1);

    logic          clk;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  y_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  peak_out;
    logic [CW-1:0] sat_count;
    logic          overrange;

    int checks;
    int failures;

    window_peak_sat #(
        .W       (W),
        .WIN     (WIN),
        .SAT_VAL (SAT_VAL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .peak_out  (peak_out),
        .sat_count (sat_count),
        .overrange (overrange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] v);
        in_valid = 1'b1;
        y_in     = v;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic chk_result(input string tag, input int pk, input int sc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_peak"},  32'(peak_out),  32'(pk));
        chk({tag, "_satc"},  32'(sat_count), 32'(sc));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        y_in      = '0;
        out_ready = 1'b1;

        // 1: reset
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_peak", 32'(peak_out), 32'd0);
        chk("rst_satc", 32'(sat_count), 32'd0);
        chk("rst_over", 32'(overrange), 32'd0);
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);

        // 2: back-to-back window
        in_valid = 1'b1;
        y_in = 8'd10; tick();
        chk("b2b_no_early", 32'(out_valid), 32'd0);
        y_in = 8'd50; tick();
        y_in = 8'd30; tick();
        y_in = 8'd20; tick();
        in_valid = 1'b0;
        #1;
        chk_result("b2b", 50, 0);
        chk("b2b_hold_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("b2b_drop", 32'(out_valid), 32'd0);

        // 3: gapped samples including saturation, held under backpressure
        send(8'd200); gap();
        send(8'd7);   gap();
        send(8'd200); gap();
        out_ready = 1'b0;
        send(8'd199);
        chk_result("gap", 200, 2);
        chk("gap_over", 32'(overrange), 32'd0);

        // 4: backpressure with a sample waiting
        in_valid = 1'b1;
        y_in = 8'd90;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk_result("bp", 200, 2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        #1;
        chk("bp_xfer_drop", 32'(out_valid), 32'd0);
        chk("bp_idle_ready", 32'(in_ready), 32'd1);
        tick();
        y_in = 8'd10; tick();
        y_in = 8'd11; tick();
        y_in = 8'd12; tick();
        in_valid = 1'b0;
        chk_result("bp_next", 90, 0);
        tick();

        // 5: overrange sample clamps and counts as saturated
        send(8'd255);
        send(8'd3);
        send(8'd4);
        send(8'd5);
        chk_result("over", 200, 1);
        chk("over_flag", 32'(overrange), 32'd1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("over_after_clear", 32'(overrange), 32'd1);

        // 6: clear aborts a partial window
        send(8'd150);
        send(8'd180);
        clear    = 1'b1;
        in_valid = 1'b1;
        y_in     = 8'd250;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        send(8'd5);
        send(8'd6);
        chk("clr_no_partial", 32'(out_valid), 32'd0);
        send(8'd7);
        send(8'd8);
        chk_result("clr", 8, 0);
        tick();

        // clear while a result is pending discards it
        out_ready = 1'b0;
        send(8'd1);
        send(8'd2);
        send(8'd200);
        send(8'd4);
        chk_result("pend", 200, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("pend_clr_valid", 32'(out_valid), 32'd0);
        chk("pend_clr_peak", 32'(peak_out), 32'd0);
        chk("pend_clr_satc", 32'(sat_count), 32'd0);
        out_ready = 1'b1;

        // rst drops the sticky flag and any partial window
        send(8'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_over", 32'(overrange), 32'd0);
        send(8'd40);
        send(8'd41);
        send(8'd42);
        chk("rst2_no_partial", 32'(out_valid), 32'd0);
        send(8'd43);
        chk_result("rst2", 43, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
